// File: rtl/ps2_click_target_fifo.sv
// ps2_click_target_fifo
//   Turns left-click presses from the PS/2 mouse position stage into a queue of
//   clamped target coordinates, presented show-ahead on a valid/ready stream to
//   the tracking-motor controller. Right press flushes the queue, middle press
//   clears the sticky overflow flag. Left presses are rate-limited by a lockout
//   counter of LOCKOUT cycles.
//
//   Optional build macro CLICK_DEDUP_EN: drop a left press whose clamped
//   coordinate equals the last pushed one while the queue is non-empty.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   x_pos, y_pos        current cursor position (10 bits each)
//   click_l/_r/_m       button levels
//   tgt_x, tgt_y        head-of-queue coordinate (held when empty)
//   tgt_valid           queue non-empty
//   tgt_ready           consumer takes the head this cycle
//   fifo_count          occupied entries
//   fifo_full           fifo_count == DEPTH
//   overflow            sticky: a press was dropped on a full queue
module ps2_click_target_fifo #(
    parameter int DEPTH   = 4,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int LOCKOUT = 5000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 x_pos,
    input  logic [9:0]                 y_pos,
    input  logic                       click_l,
    input  logic                       click_r,
    input  logic                       click_m,
    output logic [9:0]                 tgt_x,
    output logic [9:0]                 tgt_y,
    output logic                       tgt_valid,
    input  logic                       tgt_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_full,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    logic [19:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0] count_n;
    logic [LW-1:0] lock_cnt;
    logic          hist_l, hist_r, hist_m;
    logic [9:0]    cx, cy;
    logic [19:0]   head_n;
    logic          press_l, press_r, press_m;
    logic          eligible, push_req, do_push, do_pop, drop;
`ifdef CLICK_DEDUP_EN
    logic [19:0]   last_xy;
`endif

    always_comb begin
        cx       = (x_pos > 10'(X_MAX)) ? 10'(X_MAX) : x_pos;
        cy       = (y_pos > 10'(Y_MAX)) ? 10'(Y_MAX) : y_pos;
        press_l  = click_l && !hist_l;
        press_r  = click_r && !hist_r;
        press_m  = click_m && !hist_m;
        eligible = press_l && (lock_cnt == '0);
`ifdef CLICK_DEDUP_EN
        push_req = eligible && !((fifo_count != '0) && ({cx, cy} == last_xy));
`else
        push_req = eligible;
`endif
        do_pop   = 1'b0;
        do_push  = 1'b0;
        drop     = 1'b0;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = fifo_count;
        head_n   = {tgt_x, tgt_y};
        if (press_r) begin
            rd_ptr_n = wr_ptr;
            count_n  = '0;
        end else begin
            do_pop  = tgt_valid && tgt_ready;
            do_push = push_req && (!fifo_full || do_pop);
            drop    = push_req && fifo_full && !do_pop;
            if (do_push) wr_ptr_n = wr_ptr + 1'b1;
            if (do_pop)  rd_ptr_n = rd_ptr + 1'b1;
            count_n = fifo_count + CW'(do_push) - CW'(do_pop);
            // Registered show-ahead head: if the new head is the slot being
            // written this edge, forward the incoming coordinate.
            if (count_n != '0)
                head_n = (do_push && (rd_ptr_n == wr_ptr)) ? {cx, cy} : mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            tgt_valid  <= 1'b0;
            tgt_x      <= '0;
            tgt_y      <= '0;
            overflow   <= 1'b0;
            lock_cnt   <= '0;
            // History starts high so a button held through reset is not a press.
            hist_l     <= 1'b1;
            hist_r     <= 1'b1;
            hist_m     <= 1'b1;
`ifdef CLICK_DEDUP_EN
            last_xy    <= '0;
`endif
        end else begin
            if (do_push) mem[wr_ptr] <= {cx, cy};
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            fifo_count <= count_n;
            fifo_full  <= (count_n == CW'(DEPTH));
            tgt_valid  <= (count_n != '0);
            {tgt_x, tgt_y} <= head_n;
            if (drop)         overflow <= 1'b1;
            else if (press_m) overflow <= 1'b0;
            if (eligible)             lock_cnt <= LW'(LOCKOUT - 1);
            else if (lock_cnt != '0)  lock_cnt <= lock_cnt - 1'b1;
            hist_l     <= click_l;
            hist_r     <= click_r;
            hist_m     <= click_m;
`ifdef CLICK_DEDUP_EN
            if (press_r)      last_xy <= '0;
            else if (do_push) last_xy <= {cx, cy};
`endif
        end
    end

endmodule

// File: tb/tb_ps2_click_target_fifo.sv
// Directed self-checking bench for ps2_click_target_fifo (DEPTH=4, LOCKOUT=8).
module tb_ps2_click_target_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_pos, y_pos;
    logic       click_l, click_r, click_m;
    logic [9:0] tgt_x, tgt_y;
    logic       tgt_valid, tgt_ready;
    logic [2:0] fifo_count;
    logic       fifo_full, overflow;

    int compared   = 0;
    int mismatched = 0;

    ps2_click_target_fifo #(.DEPTH(4), .X_MAX(639), .Y_MAX(479), .LOCKOUT(8)) dut (
        .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .click_l(click_l), .click_r(click_r), .click_m(click_m),
        .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_left(input logic [9:0] x, input logic [9:0] y);
        x_pos = x; y_pos = y; click_l = 1'b1;
        tick();
        click_l = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        compared++; if (tgt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0b want 0", tgt_valid); end
        compared++; if (fifo_count !== 3'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        compared++; if (fifo_full !== 1'b0) begin mismatched++; $display("FAIL reset_full got %0b want 0", fifo_full); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        compared++; if (tgt_x !== 10'd0 || tgt_y !== 10'd0) begin mismatched++; $display("FAIL reset_xy got %0d,%0d want 0,0", tgt_x, tgt_y); end
        idle(1);
    endtask

    task automatic test_basic();
        press_left(10'd100, 10'd50);
        compared++; if (tgt_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid got %0b want 1", tgt_valid); end
        compared++; if (tgt_x !== 10'd100 || tgt_y !== 10'd50) begin mismatched++; $display("FAIL basic_xy got %0d,%0d want 100,50", tgt_x, tgt_y); end
        compared++; if (fifo_count !== 3'd1) begin mismatched++; $display("FAIL basic_count got %0d want 1", fifo_count); end
        tgt_ready = 1'b1; tick(); tgt_ready = 1'b0;
        compared++; if (tgt_valid !== 1'b0 || fifo_count !== 3'd0) begin mismatched++; $display("FAIL basic_pop got valid=%0b cnt=%0d want 0,0", tgt_valid, fifo_count); end
        compared++; if (tgt_x !== 10'd100) begin mismatched++; $display("FAIL basic_hold got %0d want 100", tgt_x); end
        idle(10);
    endtask

    task automatic test_clamp();
        press_left(10'd700, 10'd500);
        compared++; if (tgt_x !== 10'd639 || tgt_y !== 10'd479) begin mismatched++; $display("FAIL clamp_xy got %0d,%0d want 639,479", tgt_x, tgt_y); end
        tgt_ready = 1'b1; tick(); tgt_ready = 1'b0;
        idle(10);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            press_left(10'(i), 10'(i));
            if (i == 4) begin
                compared++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_four got full=%0b ovf=%0b want 1,0", fifo_full, overflow); end
            end
            idle(9);
        end
        compared++; if (fifo_count !== 3'd4) begin mismatched++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
        compared++; if (fifo_full !== 1'b1) begin mismatched++; $display("FAIL ovf_full got %0b want 1", fifo_full); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        tgt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            compared++; if (tgt_valid !== 1'b1 || tgt_x !== 10'(i) || tgt_y !== 10'(i)) begin mismatched++; $display("FAIL ovf_head%0d got v=%0b %0d,%0d want 1 %0d,%0d", i, tgt_valid, tgt_x, tgt_y, i, i); end
            tick();
        end
        tgt_ready = 1'b0;
        compared++; if (tgt_valid !== 1'b0 || fifo_count !== 3'd0 || fifo_full !== 1'b0) begin mismatched++; $display("FAIL ovf_drain got v=%0b cnt=%0d full=%0b want 0,0,0", tgt_valid, fifo_count, fifo_full); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        click_m = 1'b1; tick(); click_m = 1'b0;
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clear got %0b want 0", overflow); end
        idle(2);
    endtask

    task automatic test_lockout();
        press_left(10'd10, 10'd10);
        idle(2);
        press_left(10'd12, 10'd12);
        compared++; if (fifo_count !== 3'd1 || overflow !== 1'b0) begin mismatched++; $display("FAIL lock_ignore got cnt=%0d ovf=%0b want 1,0", fifo_count, overflow); end
        idle(5);
        press_left(10'd10, 10'd10);
        compared++; if (fifo_count !== 3'd2) begin mismatched++; $display("FAIL lock_expire got %0d want 2", fifo_count); end
        idle(10);
    endtask

    task automatic test_flush();
        x_pos = 10'd3; y_pos = 10'd3; click_l = 1'b1; click_r = 1'b1;
        tick();
        click_l = 1'b0; click_r = 1'b0;
        compared++; if (fifo_count !== 3'd0 || tgt_valid !== 1'b0 || fifo_full !== 1'b0) begin mismatched++; $display("FAIL flush got cnt=%0d v=%0b full=%0b want 0,0,0", fifo_count, tgt_valid, fifo_full); end
        compared++; if (tgt_x !== 10'd10) begin mismatched++; $display("FAIL flush_hold got %0d want 10", tgt_x); end
        idle(1);
        press_left(10'd4, 10'd4);
        compared++; if (fifo_count !== 3'd0) begin mismatched++; $display("FAIL flush_lock got %0d want 0", fifo_count); end
        idle(10);
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_x [4];
        exp_x[0] = 10'd7; exp_x[1] = 10'd8; exp_x[2] = 10'd11; exp_x[3] = 10'd9;
        press_left(10'd6, 10'd6);   idle(9);
        press_left(10'd7, 10'd7);   idle(9);
        press_left(10'd8, 10'd8);   idle(9);
        press_left(10'd11, 10'd11); idle(9);
        compared++; if (fifo_count !== 3'd4) begin mismatched++; $display("FAIL b2b_fill got %0d want 4", fifo_count); end
        tgt_ready = 1'b1;
        press_left(10'd9, 10'd9);
        tgt_ready = 1'b0;
        compared++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin mismatched++; $display("FAIL b2b_count got cnt=%0d full=%0b want 4,1", fifo_count, fifo_full); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL b2b_ovf got %0b want 0", overflow); end
        tgt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (tgt_x !== exp_x[i] || tgt_y !== exp_x[i]) begin mismatched++; $display("FAIL b2b_head%0d got %0d,%0d want %0d,%0d", i, tgt_x, tgt_y, exp_x[i], exp_x[i]); end
            tick();
        end
        tgt_ready = 1'b0;
        compared++; if (tgt_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_empty got %0b want 0", tgt_valid); end
        idle(10);
    endtask

    task automatic test_dedup();
        press_left(10'd20, 10'd30); idle(9);
        press_left(10'd20, 10'd30); idle(9);
`ifdef CLICK_DEDUP_EN
        compared++; if (fifo_count !== 3'd1) begin mismatched++; $display("FAIL dedup_same got %0d want 1", fifo_count); end
`else
        compared++; if (fifo_count !== 3'd2) begin mismatched++; $display("FAIL nodedup_same got %0d want 2", fifo_count); end
`endif
        press_left(10'd21, 10'd30); idle(9);
`ifdef CLICK_DEDUP_EN
        compared++; if (fifo_count !== 3'd2) begin mismatched++; $display("FAIL dedup_diff got %0d want 2", fifo_count); end
`else
        compared++; if (fifo_count !== 3'd3) begin mismatched++; $display("FAIL nodedup_diff got %0d want 3", fifo_count); end
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; click_l = 1'b1; x_pos = 10'd44; y_pos = 10'd44;
        tick();
        compared++; if (fifo_count !== 3'd0 || tgt_valid !== 1'b0 || overflow !== 1'b0) begin mismatched++; $display("FAIL rstmid_state got cnt=%0d v=%0b ovf=%0b want 0,0,0", fifo_count, tgt_valid, overflow); end
        compared++; if (tgt_x !== 10'd0 || tgt_y !== 10'd0) begin mismatched++; $display("FAIL rstmid_xy got %0d,%0d want 0,0", tgt_x, tgt_y); end
        reset = 1'b0;
        idle(2);
        compared++; if (fifo_count !== 3'd0) begin mismatched++; $display("FAIL rstmid_held got %0d want 0", fifo_count); end
        click_l = 1'b0;
        tick();
        press_left(10'd5, 10'd6);
        compared++; if (fifo_count !== 3'd1 || tgt_x !== 10'd5 || tgt_y !== 10'd6) begin mismatched++; $display("FAIL rstmid_press got cnt=%0d %0d,%0d want 1 5,6", fifo_count, tgt_x, tgt_y); end
    endtask

    initial begin
        reset = 1'b1; x_pos = '0; y_pos = '0;
        click_l = 1'b0; click_r = 1'b0; click_m = 1'b0; tgt_ready = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_overflow();
        test_lockout();
        test_flush();
        test_back_to_back();
        test_dedup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
